// File: rtl/debounced_button_bank.sv
// debounced_button_bank
//   Debounces N independent push buttons on a single clock. A shared prescaler
//   produces the tick that paces every channel. Each channel has a 2-flop
//   synchroniser, a settle counter that debounces both press and release, and
//   a saturating long-press timer.
//
// Ports
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   pb_in       raw asynchronous button inputs
//   deb_out     debounced pressed level (1 = pressed)
//   press_ev    1-cycle pulse when deb_out rises
//   release_ev  1-cycle pulse when deb_out falls
//   long_ev     1-cycle pulse, once per press, after LONG_TICKS ticks held
module debounced_button_bank #(
  parameter int N          = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int PRESCALE   = 1000,
  parameter int SETTLE     = 1000,
  parameter int LONG_TICKS = 25000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pb_in,
  output logic [N-1:0] deb_out,
  output logic [N-1:0] press_ev,
  output logic [N-1:0] release_ev,
  output logic [N-1:0] long_ev
);

  // PRESCALE=1 would give a zero-width counter; keep one bit that never moves.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_TICKS);
  localparam logic          INV    = (ACTIVE_LOW != 0);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Polarity is normalised at the first flop so everything after it sees
  // 1 = pressed, and reset leaves the synchroniser in the not-pressed state.
  logic [N-1:0] s1;
  logic [N-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pb_in ^ {N{INV}};
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SW-1:0] scnt;
    logic [LW-1:0] tmr;
    logic          deb;
    logic          pr;
    logic          rl;
    logic          lg;
    logic          flip;

    assign flip = (s2[i] != deb) && tick && (scnt == S_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scnt <= '0;
        tmr  <= '0;
        deb  <= 1'b0;
        pr   <= 1'b0;
        rl   <= 1'b0;
        lg   <= 1'b0;
      end else begin
        pr <= flip & s2[i];
        rl <= flip & ~s2[i];
        lg <= 1'b0;

        if (s2[i] == deb) begin
          scnt <= '0;
        end else if (tick) begin
          if (flip) begin
            deb  <= s2[i];
            scnt <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end

        // The timer only runs on ticks where the button was already down,
        // so the press edge itself does not count. A flip while pressed is
        // the release edge and clears the timer together with deb_out.
        if (!deb || flip) begin
          tmr <= '0;
        end else if (tick && (tmr != L_MAX)) begin
          tmr <= tmr + 1'b1;
          lg  <= (tmr == L_LAST);
        end
      end
    end

    assign deb_out[i]    = deb;
    assign press_ev[i]   = pr;
    assign release_ev[i] = rl;
    assign long_ev[i]    = lg;
  end

endmodule

// File: tb/tb_debounced_button_bank.sv
module tb_debounced_button_bank;

  localparam int SET = 4;
  localparam int LNG = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pb_a = 2'b00;
  logic [1:0] pb_b = 2'b11;
  logic [1:0] deb_a, press_a, rel_a, long_a;
  logic [1:0] deb_b, press_b, rel_b, long_b;

  always #5 clk = ~clk;

  // Instance A: active-high, tick every cycle.
  debounced_button_bank #(.N(2), .ACTIVE_LOW(0), .PRESCALE(1), .SETTLE(SET), .LONG_TICKS(LNG)) dut_a (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_a),
    .deb_out(deb_a), .press_ev(press_a), .release_ev(rel_a), .long_ev(long_a));

  // Instance B: active-low, tick every third cycle.
  debounced_button_bank #(.N(2), .ACTIVE_LOW(1), .PRESCALE(3), .SETTLE(SET), .LONG_TICKS(LNG)) dut_b (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_b),
    .deb_out(deb_b), .press_ev(press_b), .release_ev(rel_b), .long_ev(long_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
  } ev_t;

  ev_t evq[2][$];

  // Reference model: a button's pressed level is what it read two clocks
  // ago; the clean level follows once it has disagreed for SET consecutive
  // ticks; a press that has lasted LNG ticks beyond its press edge is long.
  int pre[2] = '{1, 3};
  int al[2]  = '{0, 1};
  int m_s1[2][2], m_s2[2][2], m_deb[2][2], m_run[2][2], m_tmr[2][2];
  int m_pc[2];
  bit m_tick[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0;
      m_tick[k] = 0;
      evq[k].delete();
      for (int c = 0; c < 2; c++) begin
        m_s1[k][c] = 0; m_s2[k][c] = 0; m_deb[k][c] = 0;
        m_run[k][c] = 0; m_tmr[k][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] ep, er, el, pbv;
      bit t;
      int old;
      ep = 2'b00; er = 2'b00; el = 2'b00;
      t = (m_pc[k] == pre[k] - 1);
      m_pc[k] = t ? 0 : m_pc[k] + 1;
      m_tick[k] = t;
      for (int c = 0; c < 2; c++) begin
        old = m_deb[k][c];
        if (m_s2[k][c] != m_deb[k][c]) begin
          if (t) begin
            m_run[k][c]++;
            if (m_run[k][c] == SET) begin
              m_deb[k][c] = m_s2[k][c];
              m_run[k][c] = 0;
              if (m_s2[k][c] != 0) ep[c] = 1'b1;
              else er[c] = 1'b1;
            end
          end
        end else begin
          m_run[k][c] = 0;
        end
        if (m_deb[k][c] == 0) begin
          m_tmr[k][c] = 0;
        end else if (old == 1 && t && m_tmr[k][c] < LNG) begin
          m_tmr[k][c]++;
          if (m_tmr[k][c] == LNG) el[c] = 1'b1;
        end
      end
      pbv = (k == 0) ? pb_a : pb_b;
      for (int c = 0; c < 2; c++) begin
        m_s2[k][c] = m_s1[k][c];
        m_s1[k][c] = int'(pbv[c]) ^ al[k];
      end
      if ((ep | er | el) != 2'b00) begin
        ev_t e;
        e.cyc = cyc; e.p = ep; e.r = er; e.l = el;
        evq[k].push_back(e);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        model_step();
      end
    end
  end

  // Monitor: compares the clean level every cycle and pops the scoreboard
  // whenever either the DUT or the model has an event for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic [1:0] dd, dp, dr, dl, md;
        ev_t e;
        bit have;
        dd = k ? deb_b : deb_a;
        dp = k ? press_b : press_a;
        dr = k ? rel_b : rel_a;
        dl = k ? long_b : long_a;
        md = {m_deb[k][1] != 0, m_deb[k][0] != 0};
        checks++;
        if (dd !== md) begin
          failures++;
          $display("FAIL deb_level inst%0d cyc%0d: got %b want %b", k, cyc, dd, md);
        end
        while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
          e = evq[k].pop_front();
          checks++;
          failures++;
          $display("FAIL missed_event inst%0d: cycle %0d never presented p=%b r=%b l=%b", k, e.cyc, e.p, e.r, e.l);
        end
        have = (evq[k].size() > 0 && evq[k][0].cyc == cyc);
        if (have) e = evq[k].pop_front();
        else begin
          e.cyc = cyc; e.p = 2'b00; e.r = 2'b00; e.l = 2'b00;
        end
        if (have || (dp | dr | dl) != 2'b00) begin
          checks++;
          if (dp !== e.p || dr !== e.r || dl !== e.l) begin
            failures++;
            $display("FAIL events inst%0d cyc%0d: got p=%b r=%b l=%b want p=%b r=%b l=%b",
                     k, cyc, dp, dr, dl, e.p, e.r, e.l);
          end
        end
        if (k == 1 && dp != 2'b00) begin
          checks++;
          if (!m_tick[1]) begin
            failures++;
            $display("FAIL press_on_tick inst1 cyc%0d: got press=%b on a non-tick cycle", cyc, dp);
          end
        end
      end
    end
  end

  // Stimulus always changes at negedge+1, well clear of the active edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_pb(input logic [1:0] v);
    pb_a = v;
    pb_b = ~v;
  endtask

  function automatic logic [1:0] pick(input int k, input int which);
    case (which)
      0:       return k ? press_b : press_a;
      1:       return k ? rel_b : rel_a;
      default: return k ? long_b : long_a;
    endcase
  endfunction

  // Waits for the selected pulse on all masked channels and checks the cycle
  // it lands on falls within [lo, hi].
  task automatic expect_at(input string name, input int k, input int which,
                           input logic [1:0] mask, input int lo, input int hi);
    int at;
    logic [1:0] v;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v = pick(k, which);
      if ((v & mask) == mask) begin
        at = cyc;
        break;
      end
    end
    #1;
    checks++;
    if (at < lo || at > hi) begin
      failures++;
      $display("FAIL %s: got cycle %0d want %0d..%0d", name, at, lo, hi);
    end
  endtask

  initial begin
    int t;
    int run[2];
    logic [1:0] v;

    step(3);
    rst_n = 1'b1;
    step(50);

    // Single press on channel 0, long press, release.
    t = cyc;
    set_pb(2'b01);
    expect_at("press_latency", 0, 0, 2'b01, t + 6, t + 6);
    expect_at("long_latency", 0, 2, 2'b01, t + 16, t + 16);
    step(20);
    t = cyc;
    set_pb(2'b00);
    expect_at("release_latency", 0, 1, 2'b01, t + 6, t + 6);
    step(10);

    // Bounce: 1 for three cycles, 0 for one, then held.
    set_pb(2'b01);
    step(3);
    set_pb(2'b00);
    step(1);
    t = cyc;
    set_pb(2'b01);
    expect_at("bounce_rise", 0, 0, 2'b01, t + 6, t + 6);
    set_pb(2'b00);
    step(20);

    // Both channels together, then reset mid-hold.
    t = cyc;
    set_pb(2'b11);
    expect_at("press_both", 0, 0, 2'b11, t + 6, t + 6);
    step(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({deb_a, press_a, rel_a, long_a, deb_b, press_b, rel_b, long_b} !== 16'h0) begin
      failures++;
      $display("FAIL reset_clears: got a=%b%b%b%b b=%b%b%b%b want all zero",
               deb_a, press_a, rel_a, long_a, deb_b, press_b, rel_b, long_b);
    end
    step(2);
    rst_n = 1'b1;
    t = cyc;
    expect_at("press_after_reset", 0, 0, 2'b11, t + 6, t + 6);
    set_pb(2'b00);
    step(30);

    // Prescaled, active-low instance: channel 1 only.
    t = cyc;
    set_pb(2'b10);
    expect_at("prescaled_press", 1, 0, 2'b10, t + 12, t + 14);
    set_pb(2'b00);
    step(30);

    // Randomised runs: short runs act as bounce, long runs as real presses.
    run[0] = 1;
    run[1] = 1;
    v = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          v[c] = ~v[c];
          run[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                              : int'($urandom_range(8, 60));
        end
      end
      set_pb(v);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    set_pb(2'b00);
    step(80);

    for (int k = 0; k < 2; k++) begin
      checks++;
      if (evq[k].size() != 0) begin
        failures++;
        $display("FAIL drain inst%0d: got %0d pending events want 0", k, evq[k].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion want finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
